matrix_coord_scanner: RTL
=========================

# matrix_coord_scanner

Sequential scan generator for the LED-matrix display path. It steps a column/row coordinate pair (`mdc`, `mdl`) through every cell of the matrix at a programmable dwell rate. It feeds those coordinates to the combinational column/row-to-demux-select decoder downstream. It drives the consumer side of that interface, with start/stop control, single-frame or continuous operation, and an end-of-frame pulse.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles each coordinate is held; legal range 1..65535.
- `N_COLS`, default 5: number of columns scanned; legal range 1..8.
- `N_ROWS`, default 7: number of rows scanned; legal range 1..8.
- `BLANK_LEN`, default 2: length of the blanking gap in cycles; legal range 1..255; used only when `MATRIX_SCAN_BLANK_EN` is defined.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a scan; sampled only in IDLE.
- `stop` input 1: synchronous abort; returns the block to IDLE.
- `cont` input 1: 1 = wrap to the next frame, 0 = single frame; sampled at each end of frame.
- `mdc` output 3: current column, 0..N_COLS-1.
- `mdl` output 3: current row, 0..N_ROWS-1.
- `valid` output 1: `mdc`/`mdl` denote a cell to light.
- `busy` output 1: the block is not in IDLE.
- `frame_done` output 1: one-cycle pulse after the last cell of a frame.

## Operation
- States: IDLE, SCAN, BLANK. BLANK exists only with the macro.
- Reset, asynchronous with `rst_n`=0:
  - state IDLE.
  - `mdc`=0, `mdl`=0.
  - `valid`=0, `busy`=0, `frame_done`=0.
  - dwell counter cleared.
- IDLE: `start`=1 and `stop`=0 → SCAN with coordinate (0,0), `valid`=1, `busy`=1.
- Scan order is row-major:
  - `mdc` increments 0..N_COLS-1.
  - On column wrap, `mdc` returns to 0 and `mdl` increments.
  - The last cell of a frame is (N_COLS-1, N_ROWS-1).
- SCAN: a dwell counter counts 0..PRESCALE-1. At terminal count the block advances to the next cell, or to BLANK when enabled.
- End of frame is the dwell expiry on the last cell. At that point `frame_done` pulses for one cycle, concurrent with the next state.
  - `cont`=1: restart at (0,0); `busy` stays 1; BLANK is inserted first when enabled.
  - `cont`=0: go to IDLE; `valid`=0, `busy`=0; `mdc`/`mdl` return to 0.
- `stop`=1 in any state → IDLE on the next edge.
  - All outputs take their reset values, with `frame_done`=0.
  - `stop` has priority over `start` and over dwell expiry.
- `start` while busy is ignored.
- Coordinate arithmetic is 3-bit unsigned. Values ≥ N_COLS or ≥ N_ROWS are never emitted.
- Degenerate case N_COLS=N_ROWS=1: the frame is a single cell, and `frame_done` follows every dwell.

## Timing
- Let edge k sample `start`=1 in IDLE.
- After edge k+1: cell 0 = (0,0) is presented with `valid`=1.
- Without blanking, cell i is presented after edge k+1+PRESCALE·i and held PRESCALE cycles.
- Single frame, without blanking:
  - After edge k+1+PRESCALE·N_COLS·N_ROWS: IDLE, with `frame_done`=1 for that one cycle.
  - A `start` presented in the `frame_done` cycle is accepted, giving (0,0) one edge later.
- With blanking, each cell occupies PRESCALE cycles of SCAN plus BLANK_LEN cycles of BLANK, except the final cell of a single frame, which has no BLANK.
- `busy` rises and falls on the same edges as entry to and exit from IDLE.

## Configuration
- `MATRIX_SCAN_BLANK_EN` defined:
  - After each dwell, the block enters BLANK for BLANK_LEN cycles.
  - During BLANK, `valid`=0 and `mdc`/`mdl` hold the previous cell.
  - The block then presents the next cell.
  - BLANK also sits between frames in continuous mode.
  - `stop` during BLANK → IDLE.
- `MATRIX_SCAN_BLANK_EN` undefined:
  - BLANK state, its counter and BLANK_LEN logic are absent.
  - `valid` stays 1 continuously from the first cell through end of scan.

## Test plan
- Reset mid-scan: PRESCALE=4, assert `rst_n`=0 asynchronously while at cell (2,3) → all outputs 0 immediately, without waiting for a clock edge; the block stays IDLE after release.
- Single frame: defaults, no macro, `start` pulse → 35 cells in row-major order, each held exactly 4 cycles; `frame_done` pulse 141 edges after the start edge; `busy` falls the same edge.
- Continuous: `cont`=1 → after (4,6) the next edge presents (0,0) with `frame_done`=1 and `busy` held high; run three frames and check pulse spacing is 140 cycles.
- Stop priority:
  - `stop`=1 at the dwell expiry of cell (4,6) → IDLE with no `frame_done`.
  - `start`=`stop`=1 in IDLE → stays IDLE.
- Blanking: macro defined, BLANK_LEN=2, single frame → `valid` low exactly 2 cycles between cells with coordinates held; total frame 35·4+34·2 = 208 cycles; `frame_done` after edge k+209.
- Degenerate: N_COLS=1, N_ROWS=1, PRESCALE=1, `cont`=1 → (0,0) with `valid`=1 every cycle; `frame_done` high every cycle after the first.

Source files
------------

// File: rtl/matrix_coord_scanner.sv
// Row-major (mdc, mdl) scan generator; optional inter-cell blanking via MATRIX_SCAN_BLANK_EN.
// Registered outputs: first cell one edge after start is sampled; no backpressure, runs free until stop or end of frame.
module matrix_coord_scanner #(
    parameter int PRESCALE  = 4,
    parameter int N_COLS    = 5,
    parameter int N_ROWS    = 7,
    parameter int BLANK_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    output logic [2:0] mdc,
    output logic [2:0] mdl,
    output logic       valid,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] DWELL_LAST = 16'(PRESCALE - 1);
    localparam logic [2:0]  COL_LAST   = 3'(N_COLS - 1);
    localparam logic [2:0]  ROW_LAST   = 3'(N_ROWS - 1);

`ifdef MATRIX_SCAN_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_LEN - 1);
    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
    logic [7:0] blank_cnt, blank_cnt_nxt;
`else
    typedef enum logic [0:0] {IDLE, SCAN} state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] dwell, dwell_nxt;
    logic [2:0]  mdc_nxt, mdl_nxt;
    logic        valid_nxt, busy_nxt, frame_done_nxt;

    logic        last_col, last_cell, dwell_end;
    logic [2:0]  col_adv, row_adv;

    assign last_col  = (mdc == COL_LAST);
    assign last_cell = last_col && (mdl == ROW_LAST);
    assign dwell_end = (dwell == DWELL_LAST);
    // Row-major successor; the last cell wraps naturally to (0,0).
    assign col_adv   = last_col ? 3'd0 : mdc + 3'd1;
    assign row_adv   = last_col ? ((mdl == ROW_LAST) ? 3'd0 : mdl + 3'd1) : mdl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dwell      <= 16'd0;
            mdc        <= 3'd0;
            mdl        <= 3'd0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
            blank_cnt  <= 8'd0;
`endif
        end else begin
            state      <= state_nxt;
            dwell      <= dwell_nxt;
            mdc        <= mdc_nxt;
            mdl        <= mdl_nxt;
            valid      <= valid_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
`ifdef MATRIX_SCAN_BLANK_EN
            blank_cnt  <= blank_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        dwell_nxt      = dwell;
        mdc_nxt        = mdc;
        mdl_nxt        = mdl;
        valid_nxt      = valid;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
        blank_cnt_nxt  = blank_cnt;
`endif
        if (stop) begin
            // Abort wins over start and over dwell expiry; no frame_done.
            state_nxt = IDLE;
            dwell_nxt = 16'd0;
            mdc_nxt   = 3'd0;
            mdl_nxt   = 3'd0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
            blank_cnt_nxt = 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SCAN;
                        dwell_nxt = 16'd0;
                        mdc_nxt   = 3'd0;
                        mdl_nxt   = 3'd0;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end
                SCAN: begin
                    if (dwell_end) begin
                        dwell_nxt = 16'd0;
                        if (last_cell && !cont) begin
                            state_nxt      = IDLE;
                            mdc_nxt        = 3'd0;
                            mdl_nxt        = 3'd0;
                            valid_nxt      = 1'b0;
                            busy_nxt       = 1'b0;
                            frame_done_nxt = 1'b1;
                        end else begin
`ifdef MATRIX_SCAN_BLANK_EN
                            // Coordinates hold through the gap; advance on exit.
                            state_nxt      = BLANK;
                            blank_cnt_nxt  = 8'd0;
                            valid_nxt      = 1'b0;
                            frame_done_nxt = last_cell;
`else
                            mdc_nxt        = col_adv;
                            mdl_nxt        = row_adv;
                            frame_done_nxt = last_cell;
`endif
                        end
                    end else begin
                        dwell_nxt = dwell + 16'd1;
                    end
                end
`ifdef MATRIX_SCAN_BLANK_EN
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state_nxt = SCAN;
                        mdc_nxt   = col_adv;
                        mdl_nxt   = row_adv;
                        valid_nxt = 1'b1;
                    end else begin
                        blank_cnt_nxt = blank_cnt + 8'd1;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
